// File: rtl/mem_port_arb.sv
// Two-requester arbiter sharing one memory port between fetch (IFU) and load/store (LSU).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IFU.
module mem_port_arb #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [XLEN/8-1:0] ls_bytes,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [XLEN/8-1:0] mem_bytes,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_IF = 2'd1;
    localparam logic [1:0] WAIT_LS = 2'd2;

    logic [1:0] state_q, state_d;
    logic       idle;
    logic       any_req;
    logic       pick_ls;
    logic       grant;

    assign idle    = (state_q == IDLE);
    assign any_req = if_req | ls_req;
    assign grant   = idle & mem_gnt & any_req;

`ifdef MEM_ARB_RR_EN
    // rr_q set means the LSU is favoured on the next tie.
    logic rr_q, rr_d;

    assign pick_ls = ls_req & (~if_req | rr_q);

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = ~pick_ls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign pick_ls = ls_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = pick_ls ? WAIT_LS : WAIT_IF;
                end
            end
            WAIT_IF, WAIT_LS: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Downstream payload always follows the current winner; it only matters while mem_req is high.
    assign mem_req   = idle & any_req;
    assign mem_wr    = pick_ls ? ls_wr    : 1'b0;
    assign mem_bytes = pick_ls ? ls_bytes : {(XLEN/8){1'b1}};
    assign mem_addr  = pick_ls ? ls_addr  : if_addr;
    assign mem_wdata = pick_ls ? ls_wdata : '0;

    assign if_gnt    = grant & ~pick_ls;
    assign ls_gnt    = grant & pick_ls;
    assign if_rvalid = (state_q == WAIT_IF) & mem_rvalid;
    assign ls_rvalid = (state_q == WAIT_LS) & mem_rvalid;
    assign ls_rdata  = mem_rdata;
    assign busy      = ~idle;

    generate
        if (XLEN == 64) begin : g_wide
            // Address bit 2 of the fetch picks which half of the doubleword holds the instruction.
            logic sel_hi_q, sel_hi_d;

            always_comb begin
                sel_hi_d = sel_hi_q;
                if (if_gnt) begin
                    sel_hi_d = if_addr[2];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_hi_q <= 1'b0;
                end else begin
                    sel_hi_q <= sel_hi_d;
                end
            end

            assign if_rdata = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
        end else begin : g_narrow
            assign if_rdata = mem_rdata[31:0];
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb (XLEN=64); follows MEM_ARB_RR_EN when it is defined.
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_wr;
    logic [7:0]  ls_bytes;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [7:0]  mem_bytes;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arb #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_bytes(ls_bytes), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_bytes(mem_bytes), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are compared 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; ls_req = 0; ls_wr = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    task automatic do_reset();
        step();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt got %b exp 00", {if_gnt, ls_gnt}); end
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid got %b exp 00", {if_rvalid, ls_rvalid}); end
    endtask

    task automatic test_fetch();
        step();
        if_req = 1; if_addr = 64'h8000_0004; mem_gnt = 1;
        #2;
        checks++; if ({if_gnt, ls_gnt} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_gnt got %b exp 10", {if_gnt, ls_gnt}); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mem_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 64'h8000_0004) begin errors++; $display("[TB] FAIL fetch_mem_addr got %h exp 80000004", mem_addr); end
        checks++; if ({mem_wr, mem_bytes} !== 9'h0FF) begin errors++; $display("[TB] FAIL fetch_wr_bytes got %h exp 0ff", {mem_wr, mem_bytes}); end
        step();
        if_req = 0; mem_gnt = 0;
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL fetch_busy got %b exp 1", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait_req got %b exp 0", mem_req); end
        step();
        mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
        #2;
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_rvalid got %b exp 10", {if_rvalid, ls_rvalid}); end
        checks++; if (if_rdata !== 32'h1111_2222) begin errors++; $display("[TB] FAIL fetch_rdata got %h exp 11112222", if_rdata); end
        step();
        mem_rvalid = 0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_done_busy got %b exp 0", busy); end
    endtask

    task automatic test_store();
        step();
        ls_req = 1; ls_wr = 1; ls_bytes = 8'h0F; ls_addr = 64'h100; ls_wdata = 64'hDEAD_BEEF; mem_gnt = 1;
        #2;
        checks++; if ({if_gnt, ls_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL store_gnt got %b exp 01", {if_gnt, ls_gnt}); end
        checks++; if ({mem_wr, mem_bytes} !== 9'h10F) begin errors++; $display("[TB] FAIL store_wr_bytes got %h exp 10f", {mem_wr, mem_bytes}); end
        checks++; if (mem_wdata !== 64'hDEAD_BEEF) begin errors++; $display("[TB] FAIL store_wdata got %h exp deadbeef", mem_wdata); end
        checks++; if (mem_addr !== 64'h100) begin errors++; $display("[TB] FAIL store_addr got %h exp 100", mem_addr); end
        step();
        ls_req = 0; mem_gnt = 0; mem_rvalid = 1;
        #2;
        checks++; if ({if_rvalid, ls_rvalid} !== 2'b01) begin errors++; $display("[TB] FAIL store_ack got %b exp 01", {if_rvalid, ls_rvalid}); end
        step();
        clear_inputs();
        #2;
        checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL store_ack_pulse got %b exp 0", ls_rvalid); end
    endtask

    task automatic test_ties();
        int order[4];
        int k;
        do_reset();
`ifdef MEM_ARB_RR_EN
        // Both requesters stay asserted; memory grants and answers immediately.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if_req = 1; if_addr = 64'h2000; ls_req = 1; ls_wr = 0; ls_addr = 64'h3000;
            mem_gnt = 1; mem_rvalid = (c % 2 == 1);
            mem_rdata = 64'h0;
            #2;
            if (c % 2 == 0) begin
                order[k] = if_gnt ? 1 : (ls_gnt ? 2 : 0);
                k++;
            end else begin
                checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL tie_wait_gnt got %b exp 00", {if_gnt, ls_gnt}); end
                checks++; if ({if_rvalid, ls_rvalid} !== ((order[k-1] == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("[TB] FAIL tie_rvalid got %b owner %0d", {if_rvalid, ls_rvalid}, order[k-1]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (order[i] !== ((i % 2 == 0) ? 1 : 2)) begin
                errors++; $display("[TB] FAIL tie_rr_order[%0d] got %0d exp %0d", i, order[i], (i % 2 == 0) ? 1 : 2);
            end
        end
`else
        for (int r = 0; r < 3; r++) begin
            step();
            if_req = 1; if_addr = 64'h2000; ls_req = 1; ls_wr = 0; ls_addr = 64'h3000; mem_gnt = 1; mem_rvalid = 0;
            #2;
            checks++; if ({if_gnt, ls_gnt} !== 2'b01) begin errors++; $display("[TB] FAIL tie_fixed_gnt got %b exp 01", {if_gnt, ls_gnt}); end
            step();
            ls_req = 0; mem_rvalid = 1;
            #2;
            checks++; if ({if_gnt, ls_rvalid} !== 2'b01) begin errors++; $display("[TB] FAIL tie_fixed_ls_resp got %b exp 01", {if_gnt, ls_rvalid}); end
            step();
            mem_rvalid = 0;
            #2;
            checks++; if (if_gnt !== 1'b1) begin errors++; $display("[TB] FAIL tie_fixed_if_gnt got %b exp 1", if_gnt); end
            step();
            if_req = 0; mem_rvalid = 1;
            #2;
            checks++; if (if_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL tie_fixed_if_resp got %b exp 1", if_rvalid); end
        end
`endif
        step();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        step();
        ls_req = 1; ls_wr = 0; ls_addr = 64'hABCD_0000_1234_5678; mem_gnt = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++; if ({mem_req, if_gnt, ls_gnt, busy} !== 4'b1000) begin errors++; $display("[TB] FAIL stall_ctrl[%0d] got %b exp 1000", i, {mem_req, if_gnt, ls_gnt, busy}); end
            checks++; if (mem_addr !== 64'hABCD_0000_1234_5678) begin errors++; $display("[TB] FAIL stall_addr[%0d] got %h", i, mem_addr); end
            step();
        end
        // Grant together with a stray response: grant wins, response ignored.
        mem_gnt = 1; mem_rvalid = 1;
        #2;
        checks++; if ({ls_gnt, ls_rvalid, if_rvalid} !== 3'b100) begin errors++; $display("[TB] FAIL gnt_with_stray got %b exp 100", {ls_gnt, ls_rvalid, if_rvalid}); end
        step();
        ls_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hCAFE_0000_F00D_0001;
        #2;
        checks++; if (ls_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL stall_resp got %b exp 1", ls_rvalid); end
        checks++; if (ls_rdata !== 64'hCAFE_0000_F00D_0001) begin errors++; $display("[TB] FAIL stall_rdata got %h", ls_rdata); end
        step();
        mem_rvalid = 0;
        step();
        mem_rvalid = 1;
        #2;
        checks++; if ({if_rvalid, ls_rvalid, mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL stray_idle got %b exp 000", {if_rvalid, ls_rvalid, mem_req}); end
        step();
        mem_rvalid = 0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stray_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] expG;
        step();
        ls_req = 1; ls_wr = 0; ls_addr = 64'h40; mem_gnt = 1;
        #2;
        checks++; if (ls_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_gnt got %b exp 1", ls_gnt); end
        step();
        ls_req = 0; mem_gnt = 0; rst = 1;
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before got %b exp 1", busy); end
        step();
        rst = 0; mem_rvalid = 1;
        #2;
        checks++; if ({ls_rvalid, if_rvalid, busy} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid_discard got %b exp 000", {ls_rvalid, if_rvalid, busy}); end
        step();
        mem_rvalid = 0; if_req = 1; if_addr = 64'h80; ls_req = 1; mem_gnt = 1;
`ifdef MEM_ARB_RR_EN
        expG = 2'b10;
`else
        expG = 2'b01;
`endif
        #2;
        checks++; if ({if_gnt, ls_gnt} !== expG) begin errors++; $display("[TB] FAIL rstmid_tie got %b exp %b", {if_gnt, ls_gnt}, expG); end
        step();
        clear_inputs();
        mem_rvalid = 1;
        #2;
        checks++; if ({if_rvalid, ls_rvalid} !== expG) begin errors++; $display("[TB] FAIL rstmid_tie_resp got %b exp %b", {if_rvalid, ls_rvalid}, expG); end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        int q[$];
        bit favourLs, expHi, ifPend, lsPend, winLs, anyReq;
        bit expIfG, expLsG, expIfV, expLsV, expBusy, expMemReq;
        logic [31:0] expIfData;
        do_reset();
        favourLs = 0; expHi = 0; ifPend = 0; lsPend = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (!ifPend && $urandom_range(0, 2) != 0) begin
                ifPend = 1; if_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (!lsPend && $urandom_range(0, 2) != 0) begin
                lsPend = 1; ls_wr = $urandom_range(0, 1); ls_bytes = $urandom;
                ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
            end
            if_req = ifPend; ls_req = lsPend;
            mem_gnt = $urandom_range(0, 1);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom};
            #2;
            expIfG = 0; expLsG = 0; expIfV = 0; expLsV = 0; winLs = 0;
            anyReq = ifPend | lsPend;
            if (q.size() == 0) begin
`ifdef MEM_ARB_RR_EN
                winLs = (ifPend && lsPend) ? favourLs : lsPend;
`else
                winLs = lsPend;
`endif
                expMemReq = anyReq; expBusy = 0;
                expIfG = anyReq & mem_gnt & !winLs;
                expLsG = anyReq & mem_gnt & winLs;
            end else begin
                expMemReq = 0; expBusy = 1;
                expIfV = mem_rvalid && q[0] == 0;
                expLsV = mem_rvalid && q[0] == 1;
            end
            checks++; if ({mem_req, busy} !== {expMemReq, expBusy}) begin errors++; $display("[TB] FAIL rnd_req_busy c%0d got %b exp %b", c, {mem_req, busy}, {expMemReq, expBusy}); end
            checks++; if ({if_gnt, ls_gnt} !== {expIfG, expLsG}) begin errors++; $display("[TB] FAIL rnd_gnt c%0d got %b exp %b", c, {if_gnt, ls_gnt}, {expIfG, expLsG}); end
            checks++; if ({if_rvalid, ls_rvalid} !== {expIfV, expLsV}) begin errors++; $display("[TB] FAIL rnd_rvalid c%0d got %b exp %b", c, {if_rvalid, ls_rvalid}, {expIfV, expLsV}); end
            if (expMemReq) begin
                checks++;
                if (winLs && {mem_wr, mem_bytes, mem_addr, mem_wdata} !== {ls_wr, ls_bytes, ls_addr, ls_wdata}) begin
                    errors++; $display("[TB] FAIL rnd_ls_payload c%0d got %b/%h/%h exp %b/%h/%h", c, mem_wr, mem_bytes, mem_addr, ls_wr, ls_bytes, ls_addr);
                end else if (!winLs && {mem_wr, mem_bytes, mem_addr} !== {1'b0, 8'hFF, if_addr}) begin
                    errors++; $display("[TB] FAIL rnd_if_payload c%0d got %b/%h/%h exp 0/ff/%h", c, mem_wr, mem_bytes, mem_addr, if_addr);
                end
            end
            if (expIfV) begin
                expIfData = expHi ? mem_rdata[63:32] : mem_rdata[31:0];
                checks++; if (if_rdata !== expIfData) begin errors++; $display("[TB] FAIL rnd_if_rdata c%0d got %h exp %h", c, if_rdata, expIfData); end
            end
            if (expLsV) begin
                checks++; if (ls_rdata !== mem_rdata) begin errors++; $display("[TB] FAIL rnd_ls_rdata c%0d got %h exp %h", c, ls_rdata, mem_rdata); end
            end
            if (expIfG || expLsG) begin
                q.push_back(winLs ? 1 : 0);
                favourLs = !winLs;
                if (winLs) lsPend = 0;
                else begin ifPend = 0; expHi = if_addr[2]; end
            end else if (expIfV || expLsV) begin
                void'(q.pop_front());
            end
        end
        step();
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        if_addr = '0; ls_bytes = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_ties();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
